// File: rtl/bus_rr_arbiter.sv
// N-source round-robin arbiter feeding a one-entry registered output (valid/ready both sides).
// Optional source lock (hold grant on one source across words) under BUS_ARB_LOCK_EN.
module bus_rr_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned SEL_W  = $clog2(N_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC-1:0]          in_valid,
  input  logic [N_SRC*DATA_W-1:0]   in_data,
  output logic [N_SRC-1:0]          in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_src,
  input  logic                      out_ready
`ifdef BUS_ARB_LOCK_EN
  ,
  input  logic [N_SRC-1:0]          in_lock
`endif
);

  localparam logic [0:0]       ST_EMPTY = 1'b0;
  localparam logic [0:0]       ST_FULL  = 1'b1;
  localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(N_SRC - 1);
  localparam logic [SEL_W:0]   N_WIDE   = (SEL_W + 1)'(N_SRC);

  logic [0:0]        state, state_nxt;
  logic [SEL_W-1:0]  ptr, ptr_nxt;
  logic [SEL_W-1:0]  gnt;
  logic              gnt_any;
  logic              can_load;
  logic              accept;
  logic [N_SRC-1:0]  elig;
  logic [DATA_W-1:0] gnt_data;

  // Modulo-N_SRC increment; explicit wrap so non-power-of-2 counts never overshoot.
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
    return (i == LAST_SRC) ? '0 : i + SEL_W'(1);
  endfunction

`ifdef BUS_ARB_LOCK_EN
  logic lock_hold, lock_hold_nxt;
  logic [N_SRC-1:0] ptr_mask;

  always_comb begin
    ptr_mask      = '0;
    ptr_mask[ptr] = 1'b1;
    elig          = lock_hold ? (in_valid & ptr_mask) : in_valid;
  end
`else
  assign elig = in_valid;
`endif

  // Scan ptr, ptr+1, ... wrapping at N_SRC; first eligible requester wins.
  always_comb begin
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] cand;
    gnt     = ptr;
    gnt_any = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      sum = {1'b0, ptr} + (SEL_W + 1)'(i);
      if (sum >= N_WIDE) sum = sum - N_WIDE;
      cand = sum[SEL_W-1:0];
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt     = cand;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      if (gnt == SEL_W'(k)) gnt_data = in_data[k*DATA_W +: DATA_W];
    end
  end

  assign can_load  = (state == ST_EMPTY) || out_ready;
  assign accept    = gnt_any && can_load;
  assign out_valid = (state == ST_FULL);

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gnt] = 1'b1;
  end

  // Next state, pointer and lock.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
`ifdef BUS_ARB_LOCK_EN
    lock_hold_nxt = lock_hold;
`endif
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
`ifdef BUS_ARB_LOCK_EN
    if (accept) begin
      if (in_lock[gnt]) begin
        lock_hold_nxt = 1'b1;
        ptr_nxt       = gnt;
      end else begin
        lock_hold_nxt = 1'b0;
        ptr_nxt       = wrap_inc(gnt);
      end
    end else if (lock_hold && (state == ST_EMPTY) && !in_valid[ptr]) begin
      // Locked source walked away while idle: release and move on.
      lock_hold_nxt = 1'b0;
      ptr_nxt       = wrap_inc(ptr);
    end
`else
    if (accept) ptr_nxt = wrap_inc(gnt);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

`ifdef BUS_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_hold <= 1'b0;
    else        lock_hold <= lock_hold_nxt;
  end
`endif

  // Output word register; pops without reload simply leave stale data behind out_valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= '0;
    end else if (accept) begin
      out_data <= gnt_data;
      out_src  <= gnt;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: 4-source instance with reference model, 3-source instance for wrap.
module tb_bus_rr_arbiter;

  typedef struct packed {
    logic [1:0]  src;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [63:0] in_data = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready = 1'b0;
  logic [3:0]  in_lock = '0;

  logic [2:0]  v3 = '0;
  logic [47:0] id3 = '0;
  logic [2:0]  rdy3;
  logic        ov3;
  logic [15:0] od3;
  logic [1:0]  os3;
  logic        or3 = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [15:0] d [4];
  exp_t        sb_q [$];
  exp_t        mon_e;
  logic        m_valid = 1'b0;
  logic        m_lock = 1'b0;
  logic [1:0]  m_ptr = '0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.DATA_W(16), .N_SRC(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready)
`ifdef BUS_ARB_LOCK_EN
    , .in_lock(in_lock)
`endif
  );

  bus_rr_arbiter #(.DATA_W(16), .N_SRC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(id3), .in_ready(rdy3),
    .out_valid(ov3), .out_data(od3), .out_src(os3), .out_ready(or3)
`ifdef BUS_ARB_LOCK_EN
    , .in_lock(3'b000)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pop one expected word whenever the DUT takes a word into its output register.
  always @(posedge clk) begin
    if (rst_n && (|(in_valid & in_ready))) begin
      #1;
      if (sb_q.size() == 0) begin
        chk("sb_underrun", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e.data));
        chk("out_src", 32'(out_src), 32'(mon_e.src));
      end
    end
  end

  // Drive one cycle, predict grant/handshake from the reference model, check valid after the edge.
  task automatic step(input logic [3:0] v, input logic ordy, input logic [3:0] lk);
    logic [3:0] elig;
    logic [3:0] exp_rdy;
    logic [1:0] g;
    logic [1:0] cand;
    logic       found;
    logic       can;
    logic       was_empty;
    @(negedge clk);
    in_valid  = v;
    out_ready = ordy;
    in_lock   = lk;
    for (int k = 0; k < 4; k++) in_data[k*16 +: 16] = d[k];
    elig  = m_lock ? (v & (4'b0001 << m_ptr)) : v;
    found = 1'b0;
    g     = '0;
    for (int i = 0; i < 4; i++) begin
      cand = m_ptr + 2'(i);
      if (!found && elig[cand]) begin
        found = 1'b1;
        g     = cand;
      end
    end
    was_empty = !m_valid;
    can       = was_empty || ordy;
    exp_rdy   = (found && can) ? (4'b0001 << g) : 4'b0000;
    #1 chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (found && can) begin
      sb_q.push_back('{src: g, data: d[g]});
      m_valid = 1'b1;
      if (lk[g]) begin
        m_lock = 1'b1;
        m_ptr  = g;
      end else begin
        m_lock = 1'b0;
        m_ptr  = g + 2'd1;
      end
    end else begin
      if (ordy) m_valid = 1'b0;
      if (m_lock && was_empty && !v[m_ptr]) begin
        m_lock = 1'b0;
        m_ptr  = m_ptr + 2'd1;
      end
    end
    @(posedge clk);
    #1 chk("out_valid", 32'(out_valid), 32'(m_valid));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = '0;
    in_lock  = '0;
    v3       = '0;
    m_valid  = 1'b0;
    m_lock   = 1'b0;
    m_ptr    = '0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int e5 [4];
    e5 = '{2, 0, 2, 0};
    for (int k = 0; k < 4; k++) d[k] = 16'h1000 + 16'(k);
    apply_reset();

    // Reset asserted while FULL clears outputs without waiting for a clock.
    d[2] = 16'h1234;
    step(4'b0100, 1'b0, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", 32'(out_valid), 32'd0);
    chk("t1_rst_data", 32'(out_data), 32'd0);
    chk("t1_rst_src", 32'(out_src), 32'd0);
    apply_reset();

    // Single requester.
    d[2] = 16'hBEEF;
    step(4'b0100, 1'b1, 4'b0000);
    chk("t2_data", 32'(out_data), 32'h0000BEEF);
    chk("t2_src", 32'(out_src), 32'd2);
    step(4'b0000, 1'b1, 4'b0000);

    // Fairness: all requesting, one word per cycle in rotating order.
    apply_reset();
    for (int k = 0; k < 4; k++) d[k] = 16'h2000 + 16'(k);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, 4'b0000);
      chk("t3_src", 32'(out_src), 32'(i % 4));
    end
    step(4'b0000, 1'b1, 4'b0000);

    // Backpressure: word held stable, no one accepted, then pop and reload.
    d[1] = 16'hA5A5;
    step(4'b0010, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, 4'b0000);
      chk("t4_hold_data", 32'(out_data), 32'h0000A5A5);
      chk("t4_hold_src", 32'(out_src), 32'd1);
    end
    step(4'b1111, 1'b1, 4'b0000);
    chk("t4_reload_src", 32'(out_src), 32'd2);
    step(4'b0000, 1'b1, 4'b0000);

    // Random traffic with occasional backpressure and dropped requests.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
      step(4'($urandom), ($urandom % 4) != 0, 4'b0000);
    end
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);

    // Three-source wrap: bring ptr to 2, then alternate between src2 and src0.
    id3 = {16'h00C2, 16'h00C1, 16'h00C0};
    @(negedge clk);
    v3  = 3'b010;
    or3 = 1'b1;
    #1 chk("t5_rdy_pre", 32'(rdy3), 32'h2);
    @(posedge clk);
    #1 chk("t5_src_pre", 32'(os3), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v3 = 3'b101;
      #1 chk("t5_rdy", 32'(rdy3), 32'(3'b001 << e5[i]));
      @(posedge clk);
      #1;
      chk("t5_src", 32'(os3), 32'(e5[i]));
      chk("t5_data", 32'(od3), 32'h00C0 + 32'(e5[i]));
    end
    @(negedge clk);
    v3 = 3'b000;

`ifdef BUS_ARB_LOCK_EN
    // Lock: src1 keeps the bus for three words, then rotation resumes after it releases.
    apply_reset();
    for (int k = 0; k < 4; k++) d[k] = 16'h3000 + 16'(k);
    step(4'b0001, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b1, 4'b0010);
      chk("t6_lock_src", 32'(out_src), 32'd1);
    end
    step(4'b1111, 1'b1, 4'b0000);
    chk("t6_release_src", 32'(out_src), 32'd1);
    step(4'b1111, 1'b1, 4'b0000);
    chk("t6_next_src", 32'(out_src), 32'd2);
    step(4'b0000, 1'b1, 4'b0000);
`endif

    step(4'b0000, 1'b1, 4'b0000);
    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
